// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: copies OAM_BYTES bytes from page P<<8 into OAM and arbitrates the OAM port.
// Optional macro OAM_DMA_CPU_BLOCK_EN locks the CPU out of OAM for the whole transfer.
module oam_dma_ctrl #(
    parameter int OAM_BYTES      = 160,
    parameter int STARTUP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_wr,
    input  logic [7:0]  reg_din,
    output logic [7:0]  reg_dout,
    output logic        src_req,
    output logic [15:0] src_addr,
    input  logic        src_ack,
    input  logic [7:0]  src_data,
    input  logic [7:0]  cpu_oam_addr,
    input  logic        cpu_oam_we,
    input  logic [7:0]  cpu_oam_wdata,
    output logic [7:0]  cpu_oam_rdata,
    output logic [7:0]  oam_addr,
    output logic        oam_we,
    output logic [7:0]  oam_wdata,
    input  logic [7:0]  oam_rdata,
    output logic        dma_active
);

    localparam int               CNT_W    = $clog2(STARTUP_CYCLES + 1);
    localparam logic [7:0]       LAST_IDX = 8'(OAM_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STARTUP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;

    state_t           state;
    state_t           state_next;
    logic [7:0]       page;
    logic [7:0]       idx;
    logic [7:0]       last_din;
    logic [7:0]       dma_data;
    logic [CNT_W-1:0] delay_cnt;
    logic             active;
    logic [7:0]       folded;

    // Pages 0xE0..0xFF alias into echo RAM, so bit 5 is cleared for the source address only.
    assign folded = (reg_din[7:5] == 3'b111) ? (reg_din & 8'hDF) : reg_din;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (reg_wr) begin
            state_next = START;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                START:   if (delay_cnt == CNT_ONE) state_next = READ;
                READ:    if (src_ack) state_next = WRITE;
                WRITE:   state_next = (idx == LAST_IDX) ? IDLE : READ;
                default: state_next = IDLE;
            endcase
        end
    end

    // A register write restarts from any state; a same-cycle src_ack is deliberately ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_din  <= 8'hFF;
            page      <= 8'hFF;
            idx       <= 8'h00;
            delay_cnt <= '0;
            dma_data  <= 8'h00;
            active    <= 1'b0;
        end else if (reg_wr) begin
            last_din  <= reg_din;
            page      <= folded;
            idx       <= 8'h00;
            delay_cnt <= CNT_LOAD;
            active    <= 1'b1;
        end else begin
            case (state)
                START: delay_cnt <= delay_cnt - CNT_ONE;
                READ:  if (src_ack) dma_data <= src_data;
                WRITE: begin
                    if (idx == LAST_IDX) begin
                        active <= 1'b0;
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        src_req       = (state == READ);
        src_addr      = (state == READ) ? {page, idx} : 16'h0000;
        oam_addr      = cpu_oam_addr;
        oam_we        = cpu_oam_we;
        oam_wdata     = cpu_oam_wdata;
        cpu_oam_rdata = oam_rdata;
        if (state == WRITE) begin
            oam_addr  = idx;
            oam_we    = 1'b1;
            oam_wdata = dma_data;
        end
`ifdef OAM_DMA_CPU_BLOCK_EN
        if (active && state != WRITE) begin
            oam_addr  = idx;
            oam_we    = 1'b0;
            oam_wdata = dma_data;
        end
        if (active) begin
            cpu_oam_rdata = 8'hFF;
        end
`endif
    end

    assign reg_dout   = last_din;
    assign dma_active = active;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl; honours OAM_DMA_CPU_BLOCK_EN when it is defined.
module tb_oam_dma_ctrl;

    localparam int N = 160;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_wr;
    logic [7:0]  reg_din;
    logic [7:0]  reg_dout;
    logic        src_req;
    logic [15:0] src_addr;
    logic        src_ack;
    logic [7:0]  src_data;
    logic [7:0]  cpu_oam_addr;
    logic        cpu_oam_we;
    logic [7:0]  cpu_oam_wdata;
    logic [7:0]  cpu_oam_rdata;
    logic [7:0]  oam_addr;
    logic        oam_we;
    logic [7:0]  oam_wdata;
    logic [7:0]  oam_rdata;
    logic        dma_active;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } oam_wr_t;

    oam_wr_t     exp_wr_q[$];
    logic [15:0] exp_src_q[$];
    logic [7:0]  oam_mem [256];
    int          n_checks = 0;
    int          n_pass = 0;
    int          dma_writes = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic        wr_expected = 1'b0;

    always #5 clk = ~clk;

    oam_dma_ctrl #(.OAM_BYTES(N), .STARTUP_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .reg_wr(reg_wr), .reg_din(reg_din), .reg_dout(reg_dout),
        .src_req(src_req), .src_addr(src_addr), .src_ack(src_ack), .src_data(src_data),
        .cpu_oam_addr(cpu_oam_addr), .cpu_oam_we(cpu_oam_we), .cpu_oam_wdata(cpu_oam_wdata),
        .cpu_oam_rdata(cpu_oam_rdata), .oam_addr(oam_addr), .oam_we(oam_we),
        .oam_wdata(oam_wdata), .oam_rdata(oam_rdata), .dma_active(dma_active)
    );

    function automatic logic [7:0] fold_page(input logic [7:0] p);
        return (p >= 8'hE0) ? (p & 8'hDF) : p;
    endfunction

    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return 8'(a[7:0] * 8'd7) ^ a[15:8] ^ 8'h3C;
    endfunction

    // Source memory answers after ack_delay wait cycles; OAM is a plain array.
    assign src_ack   = src_req && (wait_cnt >= ack_delay);
    assign src_data  = src_ack ? src_byte(src_addr) : 8'h00;
    assign oam_rdata = oam_mem[oam_addr];

    always @(posedge clk) begin
        wait_cnt <= (src_req && !src_ack) ? wait_cnt + 1 : 0;
        if (oam_we) oam_mem[oam_addr] <= oam_wdata;
        wr_expected <= rst && src_req && src_ack && !reg_wr;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    always @(negedge clk) begin
        oam_wr_t e;
        if (wr_expected) begin
            checkOutput("dma_we", oam_we, 1);
            checkOutput("wr_q_nonempty", exp_wr_q.size() != 0, 1);
            if (exp_wr_q.size() != 0) begin
                e = exp_wr_q.pop_front();
                checkOutput("dma_addr", oam_addr, e.addr);
                checkOutput("dma_data", oam_wdata, e.data);
            end
            dma_writes++;
        end else if (cpu_oam_we) begin
            if (dma_active) begin
`ifdef OAM_DMA_CPU_BLOCK_EN
                checkOutput("cpu_we_blocked", oam_we, 0);
`else
                checkOutput("cpu_we_pass", oam_we, 1);
                checkOutput("cpu_addr_pass", oam_addr, cpu_oam_addr);
                checkOutput("cpu_data_pass", oam_wdata, cpu_oam_wdata);
`endif
            end else begin
                checkOutput("idle_we", oam_we, 1);
                checkOutput("idle_addr", oam_addr, cpu_oam_addr);
                checkOutput("idle_data", oam_wdata, cpu_oam_wdata);
            end
        end else begin
            checkOutput("stray_we", oam_we, 0);
        end
`ifdef OAM_DMA_CPU_BLOCK_EN
        checkOutput("cpu_rdata", cpu_oam_rdata, dma_active ? 8'hFF : oam_rdata);
`else
        checkOutput("cpu_rdata", cpu_oam_rdata, oam_rdata);
`endif
        if (src_req && src_ack && !reg_wr && rst) begin
            checkOutput("src_q_nonempty", exp_src_q.size() != 0, 1);
            if (exp_src_q.size() != 0) checkOutput("src_addr", src_addr, exp_src_q.pop_front());
        end else if (src_req && exp_src_q.size() != 0) begin
            checkOutput("src_hold", src_addr, exp_src_q[0]);
        end
        if (!rst) begin
            exp_wr_q.delete();
            exp_src_q.delete();
        end else if (reg_wr) begin
            exp_wr_q.delete();
            exp_src_q.delete();
            for (int i = 0; i < N; i++) begin
                exp_src_q.push_back({fold_page(reg_din), 8'(i)});
                exp_wr_q.push_back('{addr: 8'(i), data: src_byte({fold_page(reg_din), 8'(i)})});
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] page);
        @(posedge clk); #1;
        reg_wr  = 1'b1;
        reg_din = page;
        @(posedge clk); #1;
        reg_wr  = 1'b0;
    endtask

    task automatic measureTransfer(input string tag, input int expected_cycles);
        int cycles = 0;
        int guard = 0;
        while (dma_active === 1'b1 && guard < 5000) begin
            @(negedge clk);
            if (dma_active === 1'b1) cycles++;
            guard++;
        end
        checkOutput(tag, cycles, expected_cycles);
        checkOutput({tag, "_drained"}, exp_wr_q.size(), 0);
    endtask

    task automatic waitWrites(input int base, input int count);
        int guard = 0;
        while (dma_writes - base < count && guard < 3000) begin
            @(negedge clk); #1;
            guard++;
        end
        checkOutput("wait_writes", dma_writes - base, count);
    endtask

    initial begin
        int base;
        rst = 1'b0; reg_wr = 1'b0; reg_din = 8'h00;
        cpu_oam_addr = 8'h00; cpu_oam_we = 1'b0; cpu_oam_wdata = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_reg_dout", reg_dout, 8'hFF);
        checkOutput("rst_src_req", src_req, 0);
        checkOutput("rst_src_addr", src_addr, 16'h0000);
        checkOutput("rst_dma_active", dma_active, 0);
        checkOutput("rst_oam_we", oam_we, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        $display("[TB] basic transfer from page 0xC1");
        base = dma_writes;
        applyStimulus(8'hC1);
        checkOutput("basic_reg_dout", reg_dout, 8'hC1);
        measureTransfer("basic_len", 1 + 2 * N);
        checkOutput("basic_count", dma_writes - base, N);

        $display("[TB] folded page 0xFE");
        applyStimulus(8'hFE);
        checkOutput("fold_reg_dout", reg_dout, 8'hFE);
        measureTransfer("fold_len", 1 + 2 * N);

        $display("[TB] three wait states per read");
        ack_delay = 3;
        base = dma_writes;
        applyStimulus(8'h80);
        measureTransfer("wait_len", 1 + 5 * N);
        checkOutput("wait_count", dma_writes - base, N);
        ack_delay = 0;

        $display("[TB] restart 0xC0 -> 0xD0 after 20 writes");
        base = dma_writes;
        applyStimulus(8'hC0);
        waitWrites(base, 20);
        applyStimulus(8'hD0);
        checkOutput("restart_reg_dout", reg_dout, 8'hD0);
        @(negedge clk);
        checkOutput("restart_start_req", src_req, 0);
        checkOutput("restart_active", dma_active, 1);
        @(negedge clk);
        checkOutput("restart_req", src_req, 1);
        checkOutput("restart_addr", src_addr, 16'hD000);
        measureTransfer("restart_len", 2 * N - 1);
        for (int i = 0; i < N; i++) checkOutput("restart_oam", oam_mem[i], src_byte({8'hD0, 8'(i)}));

        $display("[TB] reset at idx 50");
        base = dma_writes;
        applyStimulus(8'hC3);
        waitWrites(base, 50);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_active", dma_active, 0);
        checkOutput("midrst_req", src_req, 0);
        checkOutput("midrst_reg_dout", reg_dout, 8'hFF);
        checkOutput("midrst_we", oam_we, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("midrst_count", dma_writes - base, 50);

        $display("[TB] CPU contention at OAM 0x10");
        @(posedge clk); #1;
        cpu_oam_addr = 8'h10; cpu_oam_wdata = 8'hA5; cpu_oam_we = 1'b1;
        base = dma_writes;
        applyStimulus(8'hC5);
        measureTransfer("contend_len", 1 + 2 * N);
        checkOutput("contend_count", dma_writes - base, N);
        repeat (3) @(posedge clk);
        #1;
        cpu_oam_we = 1'b0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sequences OAM DMA transfers and shares the OAM port between the CPU and the DMA engine.
- A CPU write to register 0xFF46 with value P copies OAM_BYTES bytes from source P<<8 to OAM offsets 0x00 upward.
- The block sits between the CPU bus, the external memory read path and the OAM port that the PPU also uses.
- While a transfer runs, the DMA engine owns OAM.

Parameters:
- OAM_BYTES, 160, number of bytes copied per transfer; legal range 1..256.
- STARTUP_CYCLES, 1, idle cycles between the register write and the first source read; legal range ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- reg_wr  in  1  CPU write strobe to 0xFF46
- reg_din  in  8  CPU write data (source page)
- reg_dout  out  8  readback of the last written page
- src_req  out  1  source read request
- src_addr  out  16  source byte address
- src_ack  in  1  source data valid this cycle
- src_data  in  8  source read data
- cpu_oam_addr  in  8  CPU OAM offset
- cpu_oam_we  in  1  CPU OAM write enable
- cpu_oam_wdata  in  8  CPU OAM write data
- cpu_oam_rdata  out  8  OAM read data returned to the CPU
- oam_addr  out  8  OAM port address
- oam_we  out  1  OAM port write enable
- oam_wdata  out  8  OAM port write data
- oam_rdata  in  8  OAM port read data
- dma_active  out  1  high from the accepted write until the last byte has been written

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; reg_dout=0xFF; src_req=0; src_addr=0x0000; oam_we=0; oam_wdata=0x00; dma_active=0; idx=0; page=0xFF. Reset takes effect from any state, including mid-transfer, and leaves OAM partially written.
- Page folding: page = reg_din, except values 0xE0..0xFF, which are stored with bit 5 cleared (0xE0→0xC0, 0xFE→0xDE). reg_dout always returns the unfolded reg_din.
- States: IDLE, START, READ, WRITE.
- IDLE: when reg_wr=1, latch page, set idx=0, load the delay counter with STARTUP_CYCLES, set dma_active=1 on the next cycle, go to START.
- START: decrement the delay counter each cycle. When it reaches 0, go to READ.
- READ:
  - src_req=1 and src_addr={page, idx} are held stable until src_ack=1.
  - src_ack may arrive in the same cycle as src_req or any later cycle. There is no timeout.
  - On src_ack: capture src_data into oam_wdata, drop src_req in the next cycle, go to WRITE.
- WRITE: oam_we=1 for exactly one cycle, with oam_addr=idx.
  - If idx==OAM_BYTES-1: go to IDLE and clear dma_active in the same edge.
  - Otherwise: idx+1, go to READ.
- Throughput: with a zero-wait src_ack, each byte takes 2 cycles. A full transfer takes STARTUP_CYCLES + 2*OAM_BYTES cycles from the reg_wr edge to dma_active falling.
- Restart: reg_wr=1 in START, READ or WRITE aborts the current transfer. The block latches the new page, sets idx=0, reloads the delay counter and goes to START; dma_active stays 1. If this coincides with a WRITE cycle, that write still completes. A pending src_req is dropped on the next cycle. A src_ack arriving in the same cycle as the restart is ignored.
- idx is 8-bit and never exceeds OAM_BYTES-1; there is no wrap-around past the last byte.
- OAM port mux:
  - In IDLE, oam_addr=cpu_oam_addr, oam_we=cpu_oam_we, oam_wdata=cpu_oam_wdata, and cpu_oam_rdata=oam_rdata combinationally.
  - When dma_active=1, the DMA engine drives the port. CPU behaviour in that case is defined under Optional Feature.

Optional Feature:
- Macro: OAM_DMA_CPU_BLOCK_EN
- Defined: while dma_active=1, CPU OAM writes are dropped and cpu_oam_rdata=0xFF, matching hardware bus lockout.
- Undefined:
  - The CPU is blocked only in WRITE cycles, where the DMA write wins and the CPU write is silently dropped.
  - In START and READ the CPU passes through as in IDLE, and cpu_oam_rdata=oam_rdata.

Test Plan:
- Reset then basic transfer: release rst, write reg_din=0xC1 with src_ack tied high.
  - Source reads 0xC100..0xC19F in order, oam_we pulses at addr 0x00..0x9F with matching data.
  - dma_active is high for exactly 1+320 cycles; reg_dout=0xC1.
- Folding: write 0xFE → src_addr runs 0xDE00..0xDE9F; reg_dout=0xFE.
- Wait states: src_ack delayed by 3 cycles on each read → src_addr is stable during each wait, no duplicate or skipped OAM writes, total 1+160*5 cycles.
- Restart: write 0xC0, then 0xD0 after 20 OAM writes.
  - The next source address is 0xD000 after 1 START cycle.
  - OAM ends with bytes 0x00..0x9F from the 0xD0 page.
- Reset mid-transfer: drop rst at idx=50 → next cycle IDLE, dma_active=0, src_req=0, reg_dout=0xFF, no further oam_we.
- CPU contention with OAM_DMA_CPU_BLOCK_EN defined: cpu_oam_we=1 at 0x10 throughout the DMA → no CPU write lands, cpu_oam_rdata=0xFF. Without the macro: CPU writes land only in non-WRITE cycles.
